// File: rtl/axi2per_req_scheduler.sv
// Request-side scheduler for the AXI-to-peripheral bridge: round-robin AR vs AW/W,
// one single-beat 32-bit peripheral request in flight, burst accesses routed to the error path.
module axi2per_req_scheduler #(
  parameter int unsigned PER_ADDR_WIDTH = 32,
  parameter int unsigned PER_ID_WIDTH   = 5,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      axi_ar_valid_i,
  output logic                      axi_ar_ready_o,
  input  logic [AXI_ADDR_WIDTH-1:0] axi_ar_addr_i,
  input  logic [AXI_ID_WIDTH-1:0]   axi_ar_id_i,
  input  logic [7:0]                axi_ar_len_i,
  input  logic                      axi_aw_valid_i,
  output logic                      axi_aw_ready_o,
  input  logic [AXI_ADDR_WIDTH-1:0] axi_aw_addr_i,
  input  logic [AXI_ID_WIDTH-1:0]   axi_aw_id_i,
  input  logic [7:0]                axi_aw_len_i,
  input  logic                      axi_w_valid_i,
  output logic                      axi_w_ready_o,
  input  logic [AXI_DATA_WIDTH-1:0] axi_w_data_i,
  input  logic [7:0]                axi_w_strb_i,
  input  logic                      axi_w_last_i,
  output logic                      per_master_req_o,
  input  logic                      per_master_gnt_i,
  output logic [PER_ADDR_WIDTH-1:0] per_master_add_o,
  output logic                      per_master_we_o,
  output logic [31:0]               per_master_wdata_o,
  output logic [3:0]                per_master_be_o,
  output logic [PER_ID_WIDTH-1:0]   per_master_id_o,
  output logic                      trans_req_o,
  output logic                      trans_we_o,
  output logic [AXI_ID_WIDTH-1:0]   trans_id_o,
  output logic [AXI_ADDR_WIDTH-1:0] trans_add_o,
  output logic                      trans_ar_error_o,
  output logic [7:0]                trans_ar_len_o,
  output logic                      trans_b_error_o,
  input  logic                      trans_r_valid_i,
  input  logic                      trans_error_done_i
);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, WR_REQ, W_ACC, W_DRAIN, WAIT_RESP, WAIT_ERR, WAIT_ERR_B
  } state_e;

  state_e                    state_q, state_d;
  logic                      rr_prio_q, rr_prio_d;   // 0: read side wins a tie, 1: write side
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [AXI_ID_WIDTH-1:0]   id_q, id_d;
  logic [7:0]                len_q, len_d;
  logic [31:0]               wdata_q, wdata_d;
  logic [3:0]                be_q, be_d;
  logic                      trans_req_q, trans_req_d;
  logic                      trans_we_q, trans_we_d;
  logic                      ar_err_q, ar_err_d;
  logic                      rd_gnt, wr_gnt;

  always_comb begin
    rd_gnt = 1'b0;
    wr_gnt = 1'b0;
    if (state_q == IDLE) begin
      rd_gnt = axi_ar_valid_i && (!axi_aw_valid_i || !rr_prio_q);
      wr_gnt = axi_aw_valid_i && (!axi_ar_valid_i ||  rr_prio_q);
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_prio_d   = rr_prio_q;
    addr_d      = addr_q;
    id_d        = id_q;
    len_d       = len_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    trans_req_d = 1'b0;
    trans_we_d  = trans_we_q;
    ar_err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rd_gnt) begin
          addr_d      = axi_ar_addr_i;
          id_d        = axi_ar_id_i;
          len_d       = axi_ar_len_i;
          wdata_d     = '0;
          be_d        = 4'hF;
          trans_req_d = 1'b1;
          trans_we_d  = 1'b1;
          rr_prio_d   = 1'b1;
          if (axi_ar_len_i == 8'd0) state_d = RD_REQ;
          else begin
            ar_err_d = 1'b1;
            state_d  = WAIT_ERR;
          end
        end else if (wr_gnt) begin
          addr_d    = axi_aw_addr_i;
          id_d      = axi_aw_id_i;
          len_d     = axi_aw_len_i;
          rr_prio_d = 1'b0;
          state_d   = (axi_aw_len_i == 8'd0) ? W_ACC : W_DRAIN;
        end
      end
      W_ACC: begin
        if (axi_w_valid_i) begin
          // addr[2] picks which 32-bit lane of the 64-bit beat carries the word
          wdata_d     = addr_q[2] ? axi_w_data_i[63:32] : axi_w_data_i[31:0];
          be_d        = addr_q[2] ? axi_w_strb_i[7:4]   : axi_w_strb_i[3:0];
          trans_req_d = 1'b1;
          trans_we_d  = 1'b0;
          state_d     = WR_REQ;
        end
      end
      W_DRAIN: begin
        if (axi_w_valid_i && axi_w_last_i) begin
          trans_req_d = 1'b1;
          trans_we_d  = 1'b0;
          state_d     = WAIT_ERR_B;
        end
      end
      RD_REQ, WR_REQ: if (per_master_gnt_i)   state_d = WAIT_RESP;
      WAIT_RESP:      if (trans_r_valid_i)    state_d = IDLE;
      WAIT_ERR,
      WAIT_ERR_B:     if (trans_error_done_i) state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      rr_prio_q   <= 1'b0;
      addr_q      <= '0;
      id_q        <= '0;
      len_q       <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      trans_req_q <= 1'b0;
      trans_we_q  <= 1'b0;
      ar_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_prio_q   <= rr_prio_d;
      addr_q      <= addr_d;
      id_q        <= id_d;
      len_q       <= len_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      trans_req_q <= trans_req_d;
      trans_we_q  <= trans_we_d;
      ar_err_q    <= ar_err_d;
    end
  end

  assign axi_ar_ready_o     = rd_gnt;
  assign axi_aw_ready_o     = wr_gnt;
  assign axi_w_ready_o      = axi_w_valid_i && (state_q == W_ACC || state_q == W_DRAIN);
  assign per_master_req_o   = (state_q == RD_REQ) || (state_q == WR_REQ);
  assign per_master_we_o    = (state_q == RD_REQ);
  assign per_master_add_o   = {addr_q[PER_ADDR_WIDTH-1:2], 2'b00};
  assign per_master_wdata_o = wdata_q;
  assign per_master_be_o    = be_q;
  assign per_master_id_o    = '0;
  assign trans_req_o        = trans_req_q;
  assign trans_we_o         = trans_we_q;
  assign trans_id_o         = id_q;
  assign trans_add_o        = addr_q;
  assign trans_ar_error_o   = ar_err_q;
  assign trans_ar_len_o     = len_q;
  assign trans_b_error_o    = (state_q == WAIT_ERR_B);

endmodule

// File: tb/tb_axi2per_req_scheduler.sv
// Bench for axi2per_req_scheduler: scenario tasks plus a scoreboard of expected
// peripheral and trans_* transactions popped as the DUT produces them.
module tb_axi2per_req_scheduler;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        axi_ar_valid_i, axi_ar_ready_o;
  logic [31:0] axi_ar_addr_i;
  logic [2:0]  axi_ar_id_i;
  logic [7:0]  axi_ar_len_i;
  logic        axi_aw_valid_i, axi_aw_ready_o;
  logic [31:0] axi_aw_addr_i;
  logic [2:0]  axi_aw_id_i;
  logic [7:0]  axi_aw_len_i;
  logic        axi_w_valid_i, axi_w_ready_o;
  logic [63:0] axi_w_data_i;
  logic [7:0]  axi_w_strb_i;
  logic        axi_w_last_i;
  logic        per_master_req_o, per_master_gnt_i, per_master_we_o;
  logic [31:0] per_master_add_o, per_master_wdata_o;
  logic [3:0]  per_master_be_o;
  logic [4:0]  per_master_id_o;
  logic        trans_req_o, trans_we_o, trans_ar_error_o, trans_b_error_o;
  logic [2:0]  trans_id_o;
  logic [31:0] trans_add_o;
  logic [7:0]  trans_ar_len_o;
  logic        trans_r_valid_i, trans_error_done_i;

  always #5 clk = ~clk;

  axi2per_req_scheduler dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .axi_ar_valid_i(axi_ar_valid_i), .axi_ar_ready_o(axi_ar_ready_o),
    .axi_ar_addr_i(axi_ar_addr_i), .axi_ar_id_i(axi_ar_id_i), .axi_ar_len_i(axi_ar_len_i),
    .axi_aw_valid_i(axi_aw_valid_i), .axi_aw_ready_o(axi_aw_ready_o),
    .axi_aw_addr_i(axi_aw_addr_i), .axi_aw_id_i(axi_aw_id_i), .axi_aw_len_i(axi_aw_len_i),
    .axi_w_valid_i(axi_w_valid_i), .axi_w_ready_o(axi_w_ready_o),
    .axi_w_data_i(axi_w_data_i), .axi_w_strb_i(axi_w_strb_i), .axi_w_last_i(axi_w_last_i),
    .per_master_req_o(per_master_req_o), .per_master_gnt_i(per_master_gnt_i),
    .per_master_add_o(per_master_add_o), .per_master_we_o(per_master_we_o),
    .per_master_wdata_o(per_master_wdata_o), .per_master_be_o(per_master_be_o),
    .per_master_id_o(per_master_id_o),
    .trans_req_o(trans_req_o), .trans_we_o(trans_we_o), .trans_id_o(trans_id_o),
    .trans_add_o(trans_add_o), .trans_ar_error_o(trans_ar_error_o),
    .trans_ar_len_o(trans_ar_len_o), .trans_b_error_o(trans_b_error_o),
    .trans_r_valid_i(trans_r_valid_i), .trans_error_done_i(trans_error_done_i)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] add;
    logic [31:0] wdata;
    logic [3:0]  be;
  } per_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  id;
    logic [31:0] add;
    logic        err;
    logic [7:0]  len;
  } trn_t;

  per_t per_q[$];
  trn_t trn_q[$];
  int   checks = 0;
  int   errors = 0;
  int   req_cnt = 0;
  int   trn_cnt = 0;

  // scoreboard monitor: peripheral handshakes, trans pulses, request stability
  per_t prev_per;
  logic prev_req = 1'b0, prev_gnt = 1'b0;
  always @(negedge clk) begin
    if (!rst_ni) begin
      prev_req = 1'b0;
    end else begin
      per_t cur, pe;
      trn_t te;
      cur = '{we: per_master_we_o, add: per_master_add_o, wdata: per_master_wdata_o, be: per_master_be_o};
      if (per_master_req_o) req_cnt++;
      if (prev_req && !prev_gnt && per_master_req_o) begin
        checks++;
        if (cur !== prev_per)
          begin errors++; $display("FAIL per_hold: got %h want %h", cur, prev_per); end
      end
      if (per_master_req_o && per_master_gnt_i) begin
        checks++;
        if (per_q.size() == 0) begin
          errors++; $display("FAIL per_unexpected: got %h want none", cur);
        end else begin
          pe = per_q.pop_front();
          if (cur !== pe) begin errors++; $display("FAIL per_txn: got %h want %h", cur, pe); end
        end
      end
      if (trans_req_o) begin
        trn_cnt++;
        checks++;
        if (trn_q.size() == 0) begin
          errors++; $display("FAIL trans_unexpected: got we=%0b add=%h", trans_we_o, trans_add_o);
        end else begin
          te = trn_q.pop_front();
          if (trans_we_o !== te.we || trans_id_o !== te.id || trans_add_o !== te.add ||
              trans_ar_error_o !== te.err || (te.we && trans_ar_len_o !== te.len))
            begin
              errors++;
              $display("FAIL trans_txn: got we=%0b id=%0d add=%h err=%0b len=%0d want we=%0b id=%0d add=%h err=%0b len=%0d",
                       trans_we_o, trans_id_o, trans_add_o, trans_ar_error_o, trans_ar_len_o,
                       te.we, te.id, te.add, te.err, te.len);
            end
        end
      end
      prev_req = per_master_req_o;
      prev_gnt = per_master_gnt_i;
      prev_per = cur;
    end
  end

  task automatic do_reset();
    rst_ni = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_ni = 1'b1;
  endtask

  task automatic send_ar(input logic [31:0] a, input logic [2:0] id, input logic [7:0] len);
    int n = 0;
    axi_ar_addr_i = a; axi_ar_id_i = id; axi_ar_len_i = len; axi_ar_valid_i = 1'b1;
    @(negedge clk);
    while (!axi_ar_ready_o && n < 60) begin @(negedge clk); n++; end
    checks++;
    if (!axi_ar_ready_o) begin errors++; $display("FAIL ar_accept: ready=%0b want 1", axi_ar_ready_o); end
    @(posedge clk); #1;
    axi_ar_valid_i = 1'b0;
  endtask

  task automatic send_aw(input logic [31:0] a, input logic [2:0] id, input logic [7:0] len);
    int n = 0;
    axi_aw_addr_i = a; axi_aw_id_i = id; axi_aw_len_i = len; axi_aw_valid_i = 1'b1;
    @(negedge clk);
    while (!axi_aw_ready_o && n < 60) begin @(negedge clk); n++; end
    checks++;
    if (!axi_aw_ready_o) begin errors++; $display("FAIL aw_accept: ready=%0b want 1", axi_aw_ready_o); end
    @(posedge clk); #1;
    axi_aw_valid_i = 1'b0;
  endtask

  task automatic send_w(input logic [63:0] d, input logic [7:0] s, input logic last);
    int n = 0;
    axi_w_data_i = d; axi_w_strb_i = s; axi_w_last_i = last; axi_w_valid_i = 1'b1;
    @(negedge clk);
    while (!axi_w_ready_o && n < 60) begin @(negedge clk); n++; end
    checks++;
    if (!axi_w_ready_o) begin errors++; $display("FAIL w_accept: ready=%0b want 1", axi_w_ready_o); end
    @(posedge clk); #1;
    axi_w_valid_i = 1'b0;
  endtask

  task automatic per_gnt(input int dly);
    int n = 0;
    while (!per_master_req_o && n < 60) begin @(posedge clk); #1; n++; end
    checks++;
    if (!per_master_req_o) begin
      errors++; $display("FAIL per_req_wait: req=%0b want 1", per_master_req_o);
    end else begin
      repeat (dly - 1) begin @(posedge clk); #1; end
      per_master_gnt_i = 1'b1;
      @(posedge clk); #1;
      per_master_gnt_i = 1'b0;
    end
  endtask

  task automatic resp();
    trans_r_valid_i = 1'b1;
    @(posedge clk); #1;
    trans_r_valid_i = 1'b0;
  endtask

  task automatic err_done();
    trans_error_done_i = 1'b1;
    @(posedge clk); #1;
    trans_error_done_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if ({per_master_req_o, per_master_we_o, per_master_add_o, per_master_wdata_o, per_master_be_o,
         per_master_id_o} !== '0)
      begin errors++; $display("FAIL reset_per: got req=%0b add=%h be=%h want all 0",
                               per_master_req_o, per_master_add_o, per_master_be_o); end
    checks++;
    if ({trans_req_o, trans_we_o, trans_id_o, trans_add_o, trans_ar_error_o, trans_ar_len_o,
         trans_b_error_o} !== '0)
      begin errors++; $display("FAIL reset_trans: got req=%0b add=%h want all 0", trans_req_o, trans_add_o); end
    checks++;
    if ({axi_ar_ready_o, axi_aw_ready_o, axi_w_ready_o} !== 3'b000)
      begin errors++; $display("FAIL reset_ready: got %b want 000", {axi_ar_ready_o, axi_aw_ready_o, axi_w_ready_o}); end
    @(posedge clk); #1;
  endtask

  task automatic test_read();
    req_cnt = 0; trn_cnt = 0;
    trn_q.push_back('{we: 1'b1, id: 3'd2, add: 32'h1004, err: 1'b0, len: 8'd0});
    per_q.push_back('{we: 1'b1, add: 32'h1004, wdata: 32'h0, be: 4'hF});
    send_ar(32'h1004, 3'd2, 8'd0);
    @(negedge clk);
    checks++;
    if (per_master_req_o !== 1'b1 || per_master_add_o !== 32'h1004 || per_master_we_o !== 1'b1)
      begin errors++; $display("FAIL read_req: got req=%0b add=%h we=%0b want 1 00001004 1",
                               per_master_req_o, per_master_add_o, per_master_we_o); end
    per_gnt(3);
    resp();
    @(negedge clk);
    checks++;
    if (req_cnt !== 3 || trn_cnt !== 1)
      begin errors++; $display("FAIL read_counts: got req_cycles=%0d trans=%0d want 3 1", req_cnt, trn_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_write();
    trn_q.push_back('{we: 1'b0, id: 3'd1, add: 32'h2000, err: 1'b0, len: 8'd0});
    per_q.push_back('{we: 1'b0, add: 32'h2000, wdata: 32'h11223344, be: 4'h0});
    send_aw(32'h2000, 3'd1, 8'd0);
    send_w(64'hAABBCCDD_11223344, 8'hF0, 1'b1);
    @(negedge clk);
    checks++;
    if (per_master_wdata_o !== 32'h11223344 || per_master_be_o !== 4'h0 || per_master_we_o !== 1'b0)
      begin errors++; $display("FAIL write_lane0: got wdata=%h be=%h we=%0b want 11223344 0 0",
                               per_master_wdata_o, per_master_be_o, per_master_we_o); end
    per_gnt(2);
    resp();
    trn_q.push_back('{we: 1'b0, id: 3'd1, add: 32'h2004, err: 1'b0, len: 8'd0});
    per_q.push_back('{we: 1'b0, add: 32'h2004, wdata: 32'hAABBCCDD, be: 4'hF});
    send_aw(32'h2004, 3'd1, 8'd0);
    send_w(64'hAABBCCDD_11223344, 8'hF0, 1'b1);
    @(negedge clk);
    checks++;
    if (per_master_wdata_o !== 32'hAABBCCDD || per_master_be_o !== 4'hF)
      begin errors++; $display("FAIL write_lane1: got wdata=%h be=%h want aabbccdd f",
                               per_master_wdata_o, per_master_be_o); end
    per_gnt(1);
    resp();
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int r = 0; r < 2; r++) begin
      logic [31:0] ra, wa;
      logic [2:0]  rid, wid;
      ra = 32'h3000 + 32'(r) * 32'h10;
      wa = 32'h4008 + 32'(r) * 32'h4;
      rid = 3'(1 + r); wid = 3'(5 + r);
      trn_q.push_back('{we: 1'b1, id: rid, add: ra, err: 1'b0, len: 8'd0});
      trn_q.push_back('{we: 1'b0, id: wid, add: wa, err: 1'b0, len: 8'd0});
      per_q.push_back('{we: 1'b1, add: ra, wdata: 32'h0, be: 4'hF});
      per_q.push_back('{we: 1'b0, add: wa,
                        wdata: (r == 0) ? 32'hCAFEF00D : 32'hDEADBEEF,
                        be:    (r == 0) ? 4'hC : 4'h3});
      fork
        send_ar(ra, rid, 8'd0);
        send_aw(wa, wid, 8'd0);
        begin
          per_gnt(2);
          resp();
          send_w(64'hDEADBEEF_CAFEF00D, 8'h3C, 1'b1);
          per_gnt(1);
          resp();
        end
      join
    end
  endtask

  task automatic test_ar_burst_err();
    req_cnt = 0;
    trn_q.push_back('{we: 1'b1, id: 3'd4, add: 32'h5000, err: 1'b1, len: 8'd3});
    send_ar(32'h5000, 3'd4, 8'd3);
    @(negedge clk);
    checks++;
    if (trans_ar_error_o !== 1'b1 || trans_ar_len_o !== 8'd3 || trans_req_o !== 1'b1)
      begin errors++; $display("FAIL ar_err_pulse: got err=%0b len=%0d req=%0b want 1 3 1",
                               trans_ar_error_o, trans_ar_len_o, trans_req_o); end
    @(posedge clk); #1;
    axi_ar_addr_i = 32'h5004; axi_ar_id_i = 3'd4; axi_ar_len_i = 8'd0; axi_ar_valid_i = 1'b1;
    trans_r_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (axi_ar_ready_o !== 1'b0 || trans_ar_error_o !== 1'b0)
        begin errors++; $display("FAIL ar_blocked: got ready=%0b err=%0b want 0 0",
                                 axi_ar_ready_o, trans_ar_error_o); end
      @(posedge clk); #1;
      trans_r_valid_i = 1'b0;
    end
    checks++;
    if (req_cnt !== 0) begin errors++; $display("FAIL ar_err_noreq: got req_cycles=%0d want 0", req_cnt); end
    trn_q.push_back('{we: 1'b1, id: 3'd4, add: 32'h5004, err: 1'b0, len: 8'd0});
    per_q.push_back('{we: 1'b1, add: 32'h5004, wdata: 32'h0, be: 4'hF});
    err_done();
    send_ar(32'h5004, 3'd4, 8'd0);
    per_gnt(1);
    resp();
  endtask

  task automatic test_aw_burst_err();
    req_cnt = 0;
    trn_q.push_back('{we: 1'b0, id: 3'd7, add: 32'h6000, err: 1'b0, len: 8'd2});
    send_aw(32'h6000, 3'd7, 8'd2);
    send_w(64'h1, 8'hFF, 1'b0);
    send_w(64'h2, 8'hFF, 1'b0);
    send_w(64'h3, 8'hFF, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (trans_b_error_o !== 1'b1)
        begin errors++; $display("FAIL b_err_held: got %0b want 1", trans_b_error_o); end
    end
    @(posedge clk); #1;
    err_done();
    @(negedge clk);
    checks++;
    if (trans_b_error_o !== 1'b0 || req_cnt !== 0)
      begin errors++; $display("FAIL b_err_done: got b_err=%0b req_cycles=%0d want 0 0",
                               trans_b_error_o, req_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_req();
    trn_q.push_back('{we: 1'b1, id: 3'd3, add: 32'h7000, err: 1'b0, len: 8'd0});
    send_ar(32'h7000, 3'd3, 8'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_ni = 1'b0;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    @(negedge clk);
    checks++;
    if (per_master_req_o !== 1'b0 || per_master_add_o !== 32'h0 || trans_req_o !== 1'b0 || per_master_be_o !== 4'h0)
      begin errors++; $display("FAIL reset_mid: got req=%0b add=%h treq=%0b be=%h want 0 0 0 0",
                               per_master_req_o, per_master_add_o, trans_req_o, per_master_be_o); end
    @(posedge clk); #1;
    trn_q.push_back('{we: 1'b1, id: 3'd0, add: 32'h7008, err: 1'b0, len: 8'd0});
    per_q.push_back('{we: 1'b1, add: 32'h7008, wdata: 32'h0, be: 4'hF});
    send_ar(32'h7008, 3'd0, 8'd0);
    per_gnt(2);
    resp();
  endtask

  initial begin
    rst_ni = 1'b0;
    axi_ar_valid_i = 0; axi_ar_addr_i = 0; axi_ar_id_i = 0; axi_ar_len_i = 0;
    axi_aw_valid_i = 0; axi_aw_addr_i = 0; axi_aw_id_i = 0; axi_aw_len_i = 0;
    axi_w_valid_i = 0; axi_w_data_i = 0; axi_w_strb_i = 0; axi_w_last_i = 0;
    per_master_gnt_i = 0; trans_r_valid_i = 0; trans_error_done_i = 0;
    test_reset();
    test_read();
    test_write();
    test_round_robin();
    test_ar_burst_err();
    test_aw_burst_err();
    test_reset_mid_req();
    repeat (3) @(posedge clk);
    checks++;
    if (per_q.size() != 0 || trn_q.size() != 0)
      begin errors++; $display("FAIL scoreboard_drain: got per=%0d trans=%0d left want 0 0",
                               per_q.size(), trn_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
